// File: rtl/cache_refill_ctrl_dm.sv
// Direct-mapped cache line refill controller: optional dirty-victim writeback, then word-by-word refill.
// Writeback path is built only when CACHE_WBACK_EN is defined.
module cache_refill_ctrl_dm #(
    parameter int unsigned ENTRY_NUM    = 16,
    parameter int unsigned ENTRYSEL_WID = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1,
    parameter int unsigned TAG_WID      = 14,
    parameter int unsigned LINE_WORDS   = 8,
    parameter int unsigned WORDSEL_WID  = $clog2(LINE_WORDS),
    parameter int unsigned DATA_WID     = 32,
    parameter int unsigned ADDR_WID     = TAG_WID + ENTRYSEL_WID + WORDSEL_WID + 2
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_line_miss,
    input  logic                                i_replace_dirty,
    input  logic [ENTRYSEL_WID-1:0]             i_entry_sel,
    input  logic [TAG_WID-1:0]                  i_miss_tag,
    input  logic [TAG_WID-1:0]                  i_victim_tag,
    output logic [TAG_WID-1:0]                  o_refill_tag,
    output logic                                o_line_refill,
    output logic                                o_writeback_ok,
    output logic                                o_busy,
    output logic [ENTRYSEL_WID+WORDSEL_WID-1:0] o_cmem_addr,
    output logic                                o_cmem_re,
    input  logic [DATA_WID-1:0]                 i_cmem_rdata,
    output logic                                o_cmem_we,
    output logic [DATA_WID-1:0]                 o_cmem_wdata,
    output logic                                o_bus_req,
    output logic                                o_bus_we,
    output logic [ADDR_WID-1:0]                 o_bus_addr,
    output logic [DATA_WID-1:0]                 o_bus_wdata,
    input  logic                                i_bus_ack,
    input  logic [DATA_WID-1:0]                 i_bus_rdata
);

    localparam int unsigned CADDR_WID = ENTRYSEL_WID + WORDSEL_WID;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WB_RD  = 3'd1;
    localparam logic [2:0] S_WB_BUS = 3'd2;
    localparam logic [2:0] S_WB_FIN = 3'd3;
    localparam logic [2:0] S_RF_BUS = 3'd4;
    localparam logic [2:0] S_RF_FIN = 3'd5;

    localparam logic [WORDSEL_WID-1:0] K_LAST = WORDSEL_WID'(LINE_WORDS - 1);

    logic [2:0]              r_state,      w_state_nx;
    logic [ENTRYSEL_WID-1:0] r_entry,      w_entry_nx;
    logic [TAG_WID-1:0]      r_miss_tag,   w_miss_tag_nx;
    logic [WORDSEL_WID-1:0]  r_k,          w_k_nx;
    logic [TAG_WID-1:0]      r_refill_tag, w_refill_tag_nx;
    logic                    r_line_refill, w_line_refill_nx;
    logic                    r_busy,       w_busy_nx;
    logic [CADDR_WID-1:0]    r_cmem_addr,  w_cmem_addr_nx;
    logic                    r_cmem_we,    w_cmem_we_nx;
    logic [DATA_WID-1:0]     r_cmem_wdata, w_cmem_wdata_nx;
    logic                    r_bus_req,    w_bus_req_nx;
    logic [ADDR_WID-1:0]     r_bus_addr,   w_bus_addr_nx;
`ifdef CACHE_WBACK_EN
    logic [TAG_WID-1:0]      r_victim_tag, w_victim_tag_nx;
    logic                    r_cmem_re,    w_cmem_re_nx;
    logic                    r_bus_we,     w_bus_we_nx;
    logic [DATA_WID-1:0]     r_wb_buf,     w_wb_buf_nx;
    logic                    r_wb_ok,      w_wb_ok_nx;
    logic                    r_rd_ph,      w_rd_ph_nx;
`else
    logic                    w_unused_ok;
    assign w_unused_ok = ^{i_replace_dirty, i_victim_tag, i_cmem_rdata};
`endif

    // Next-state and next-output decode; every registered output is computed one cycle ahead.
    always_comb begin
        w_state_nx       = r_state;
        w_entry_nx       = r_entry;
        w_miss_tag_nx    = r_miss_tag;
        w_k_nx           = r_k;
        w_refill_tag_nx  = r_refill_tag;
        w_line_refill_nx = 1'b0;
        w_cmem_addr_nx   = r_cmem_addr;
        w_cmem_we_nx     = 1'b0;
        w_cmem_wdata_nx  = r_cmem_wdata;
        w_bus_req_nx     = 1'b0;
        w_bus_addr_nx    = r_bus_addr;
`ifdef CACHE_WBACK_EN
        w_victim_tag_nx  = r_victim_tag;
        w_cmem_re_nx     = 1'b0;
        w_bus_we_nx      = 1'b0;
        w_wb_buf_nx      = r_wb_buf;
        w_wb_ok_nx       = 1'b0;
        w_rd_ph_nx       = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_line_miss) begin
                    w_entry_nx    = i_entry_sel;
                    w_miss_tag_nx = i_miss_tag;
                    w_k_nx        = '0;
`ifdef CACHE_WBACK_EN
                    w_victim_tag_nx = i_victim_tag;
                    if (i_replace_dirty) begin
                        w_state_nx     = S_WB_RD;
                        w_cmem_re_nx   = 1'b1;
                        w_cmem_addr_nx = {i_entry_sel, WORDSEL_WID'(0)};
                    end else
`endif
                    begin
                        w_state_nx    = S_RF_BUS;
                        w_bus_req_nx  = 1'b1;
                        w_bus_addr_nx = {i_miss_tag, i_entry_sel, WORDSEL_WID'(0), 2'b00};
                    end
                end
            end
`ifdef CACHE_WBACK_EN
            // Read issued in phase 0; RAM data is valid and captured in phase 1.
            S_WB_RD: begin
                if (!r_rd_ph) begin
                    w_rd_ph_nx = 1'b1;
                end else begin
                    w_state_nx    = S_WB_BUS;
                    w_wb_buf_nx   = i_cmem_rdata;
                    w_bus_req_nx  = 1'b1;
                    w_bus_we_nx   = 1'b1;
                    w_bus_addr_nx = {r_victim_tag, r_entry, r_k, 2'b00};
                end
            end
            S_WB_BUS: begin
                if (i_bus_ack) begin
                    if (r_k == K_LAST) begin
                        w_k_nx     = '0;
                        w_state_nx = S_WB_FIN;
                        w_wb_ok_nx = 1'b1;
                    end else begin
                        w_k_nx         = r_k + WORDSEL_WID'(1);
                        w_state_nx     = S_WB_RD;
                        w_cmem_re_nx   = 1'b1;
                        w_cmem_addr_nx = {r_entry, r_k + WORDSEL_WID'(1)};
                    end
                end else begin
                    w_bus_req_nx = 1'b1;
                    w_bus_we_nx  = 1'b1;
                end
            end
            S_WB_FIN: begin
                w_state_nx    = S_RF_BUS;
                w_bus_req_nx  = 1'b1;
                w_bus_addr_nx = {r_miss_tag, r_entry, r_k, 2'b00};
            end
`endif
            S_RF_BUS: begin
                w_bus_req_nx = 1'b1;
                if (i_bus_ack) begin
                    w_cmem_we_nx    = 1'b1;
                    w_cmem_addr_nx  = {r_entry, r_k};
                    w_cmem_wdata_nx = i_bus_rdata;
                    if (r_k == K_LAST) begin
                        w_k_nx           = '0;
                        w_state_nx       = S_RF_FIN;
                        w_bus_req_nx     = 1'b0;
                        w_line_refill_nx = 1'b1;
                        w_refill_tag_nx  = r_miss_tag;
                    end else begin
                        w_k_nx        = r_k + WORDSEL_WID'(1);
                        w_bus_addr_nx = {r_miss_tag, r_entry, r_k + WORDSEL_WID'(1), 2'b00};
                    end
                end
            end
            S_RF_FIN: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
        w_busy_nx = (w_state_nx != S_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= S_IDLE;
            r_entry       <= '0;
            r_miss_tag    <= '0;
            r_k           <= '0;
            r_refill_tag  <= '0;
            r_line_refill <= 1'b0;
            r_busy        <= 1'b0;
            r_cmem_addr   <= '0;
            r_cmem_we     <= 1'b0;
            r_cmem_wdata  <= '0;
            r_bus_req     <= 1'b0;
            r_bus_addr    <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_entry       <= w_entry_nx;
            r_miss_tag    <= w_miss_tag_nx;
            r_k           <= w_k_nx;
            r_refill_tag  <= w_refill_tag_nx;
            r_line_refill <= w_line_refill_nx;
            r_busy        <= w_busy_nx;
            r_cmem_addr   <= w_cmem_addr_nx;
            r_cmem_we     <= w_cmem_we_nx;
            r_cmem_wdata  <= w_cmem_wdata_nx;
            r_bus_req     <= w_bus_req_nx;
            r_bus_addr    <= w_bus_addr_nx;
        end
    end

`ifdef CACHE_WBACK_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_victim_tag <= '0;
            r_cmem_re    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_wb_buf     <= '0;
            r_wb_ok      <= 1'b0;
            r_rd_ph      <= 1'b0;
        end else begin
            r_victim_tag <= w_victim_tag_nx;
            r_cmem_re    <= w_cmem_re_nx;
            r_bus_we     <= w_bus_we_nx;
            r_wb_buf     <= w_wb_buf_nx;
            r_wb_ok      <= w_wb_ok_nx;
            r_rd_ph      <= w_rd_ph_nx;
        end
    end

    assign o_cmem_re      = r_cmem_re;
    assign o_bus_we       = r_bus_we;
    assign o_bus_wdata    = r_wb_buf;
    assign o_writeback_ok = r_wb_ok;
`else
    assign o_cmem_re      = 1'b0;
    assign o_bus_we       = 1'b0;
    assign o_bus_wdata    = '0;
    assign o_writeback_ok = 1'b0;
`endif

    assign o_refill_tag  = r_refill_tag;
    assign o_line_refill = r_line_refill;
    assign o_busy        = r_busy;
    assign o_cmem_addr   = r_cmem_addr;
    assign o_cmem_we     = r_cmem_we;
    assign o_cmem_wdata  = r_cmem_wdata;
    assign o_bus_req     = r_bus_req;
    assign o_bus_addr    = r_bus_addr;

endmodule

// File: tb/tb_cache_refill_ctrl_dm.sv
// Directed bench for cache_refill_ctrl_dm with a bus responder and a synchronous data RAM model.
// Test 3 (writeback) runs when CACHE_WBACK_EN is defined, test 4 otherwise.
module tb_cache_refill_ctrl_dm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        line_miss, replace_dirty;
    logic [3:0]  entry_sel;
    logic [13:0] miss_tag, victim_tag, refill_tag;
    logic        line_refill, writeback_ok, busy;
    logic [6:0]  cmem_addr;
    logic        cmem_re, cmem_we;
    logic [31:0] cmem_rdata, cmem_wdata;
    logic        bus_req, bus_we, bus_ack;
    logic [22:0] bus_addr;
    logic [31:0] bus_wdata, bus_rdata;

    always #5 clk = ~clk;

    cache_refill_ctrl_dm dut (
        .i_clk(clk), .i_rst(rst_n), .i_line_miss(line_miss), .i_replace_dirty(replace_dirty),
        .i_entry_sel(entry_sel), .i_miss_tag(miss_tag), .i_victim_tag(victim_tag),
        .o_refill_tag(refill_tag), .o_line_refill(line_refill), .o_writeback_ok(writeback_ok),
        .o_busy(busy), .o_cmem_addr(cmem_addr), .o_cmem_re(cmem_re), .i_cmem_rdata(cmem_rdata),
        .o_cmem_we(cmem_we), .o_cmem_wdata(cmem_wdata), .o_bus_req(bus_req), .o_bus_we(bus_we),
        .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata), .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata)
    );

    // Bus responder: acks after ack_dly waiting cycles; read data encodes the word index.
    int ack_dly = 0;
    int ack_cnt = 0;
    assign bus_ack   = bus_req && (ack_cnt == ack_dly);
    assign bus_rdata = 32'hA000_0000 + 32'(bus_addr[4:2]);
    always @(posedge clk) begin
        if (!bus_req || bus_ack) ack_cnt <= 0;
        else                     ack_cnt <= ack_cnt + 1;
    end

    logic [31:0] mem [0:127];
    logic        preload = 1'b0;
    always @(posedge clk) begin
        if (preload)
            for (int k = 0; k < 8; k++) mem[24+k] <= 32'hB0 + 32'(k);
        if (cmem_we) mem[cmem_addr] <= cmem_wdata;
        if (cmem_re) cmem_rdata <= mem[cmem_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Negedge monitor: cycle stamps relative to the miss cycle t0, beat and write bookkeeping.
    int cyc = 0, t0 = 0;
    int rf_rel, idle_rel, wb_rel, first_rd_rel;
    int n_we, n_rf, n_wbok, n_rd, n_wr;
    int err_addr, err_data, err_rdaddr, err_wb, err_stable, err_both;
    logic [13:0] rtag;
    logic        prev_req = 1'b0, prev_ack = 1'b0;
    logic [22:0] prev_addr = '0;

    task automatic clr();
        rf_rel = -1; idle_rel = -1; wb_rel = -1; first_rd_rel = -1;
        n_we = 0; n_rf = 0; n_wbok = 0; n_rd = 0; n_wr = 0;
        err_addr = 0; err_data = 0; err_rdaddr = 0; err_wb = 0; err_stable = 0; err_both = 0;
        rtag = '0;
    endtask

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cmem_we) begin
            n_we++;
            if (cmem_addr[6:3] != 4'd3) err_addr++;
            if (cmem_wdata != 32'hA000_0000 + 32'(cmem_addr[2:0])) err_data++;
        end
        if (line_refill) begin n_rf++; rf_rel = cyc - t0; rtag = refill_tag; end
        if (writeback_ok) begin n_wbok++; wb_rel = cyc - t0; end
        if (line_refill && writeback_ok) err_both++;
        if (bus_req && bus_ack) begin
            if (bus_we) begin
                n_wr++;
                if (bus_addr != {14'h005, 4'd3, 3'((n_wr-1) % 8), 2'b00}) err_wb++;
                if (bus_wdata != 32'hB0 + 32'((n_wr-1) % 8)) err_wb++;
            end else begin
                n_rd++;
                if (n_rd == 1) first_rd_rel = cyc - t0;
                if (bus_addr != {14'h012, 4'd3, 3'((n_rd-1) % 8), 2'b00}) err_rdaddr++;
            end
        end
        if (prev_req && !prev_ack && (!bus_req || bus_addr != prev_addr)) err_stable++;
        if (!busy && cyc > t0 && idle_rel < 0) idle_rel = cyc - t0;
        prev_req = bus_req; prev_ack = bus_ack; prev_addr = bus_addr;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic start_miss(input logic dirty);
        clr();
        t0 = cyc + 1;
        line_miss = 1'b1; replace_dirty = dirty;
        entry_sel = 4'd3; miss_tag = 14'h012; victim_tag = 14'h005;
        step(1);
        line_miss = 1'b0;
    endtask

    initial begin
        clr();
        rst_n = 1'b0; line_miss = 1'b0; replace_dirty = 1'b0;
        entry_sel = '0; miss_tag = '0; victim_tag = '0;
        step(3);
        check("rst_bus_req", 64'(bus_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_line_refill", 64'(line_refill), 64'd0);
        check("rst_cmem_we", 64'(cmem_we), 64'd0);
        rst_n = 1'b1;
        step(2);

        // 1: clean miss, zero-wait bus
        start_miss(1'b0);
        step(15);
        check("t1_refill_cycle", 64'(rf_rel), 64'd9);
        check("t1_refill_tag", 64'(rtag), 64'h012);
        check("t1_idle_cycle", 64'(idle_rel), 64'd10);
        check("t1_first_read", 64'(first_rd_rel), 64'd1);
        check("t1_reads", 64'(n_rd), 64'd8);
        check("t1_cmem_writes", 64'(n_we), 64'd8);
        check("t1_read_addr_errs", 64'(err_rdaddr), 64'd0);
        check("t1_write_addr_errs", 64'(err_addr), 64'd0);
        check("t1_write_data_errs", 64'(err_data), 64'd0);
        check("t1_refills", 64'(n_rf), 64'd1);
        for (int k = 0; k < 8; k++)
            check($sformatf("t1_mem%0d", 24+k), 64'(mem[24+k]), 64'(32'hA000_0000 + 32'(k)));

        // 2: three wait cycles per beat
        ack_dly = 3;
        start_miss(1'b0);
        step(45);
        check("t2_refill_cycle", 64'(rf_rel), 64'd33);
        check("t2_idle_cycle", 64'(idle_rel), 64'd34);
        check("t2_stable_errs", 64'(err_stable), 64'd0);
        check("t2_cmem_writes", 64'(n_we), 64'd8);
        check("t2_reads", 64'(n_rd), 64'd8);
        check("t2_data_errs", 64'(err_data), 64'd0);
        ack_dly = 0;

`ifdef CACHE_WBACK_EN
        // 3: dirty victim written back before the refill
        preload = 1'b1; step(1); preload = 1'b0; step(1);
        start_miss(1'b1);
        step(45);
        check("t3_bus_writes", 64'(n_wr), 64'd8);
        check("t3_wb_errs", 64'(err_wb), 64'd0);
        check("t3_wbok_count", 64'(n_wbok), 64'd1);
        check("t3_wbok_cycle", 64'(wb_rel), 64'd25);
        check("t3_first_read", 64'(first_rd_rel), 64'd26);
        check("t3_refill_cycle", 64'(rf_rel), 64'd34);
        check("t3_cmem_writes", 64'(n_we), 64'd8);
        check("t3_both_pulses", 64'(err_both), 64'd0);
        check("t3_read_addr_errs", 64'(err_rdaddr), 64'd0);
`else
        // 4: dirty flag ignored without the writeback path
        start_miss(1'b1);
        step(15);
        check("t4_bus_writes", 64'(n_wr), 64'd0);
        check("t4_wbok_count", 64'(n_wbok), 64'd0);
        check("t4_refill_cycle", 64'(rf_rel), 64'd9);
        check("t4_cmem_writes", 64'(n_we), 64'd8);
`endif

        // 5: reset during the refill
        start_miss(1'b0);
        for (int i = 0; i < 20 && n_rd < 4; i++) step(1);
        check("t5_reads_before_rst", 64'(n_rd), 64'd4);
        rst_n = 1'b0;
        step(1);
        check("t5_bus_req_after_rst", 64'(bus_req), 64'd0);
        check("t5_busy_after_rst", 64'(busy), 64'd0);
        step(2);
        rst_n = 1'b1;
        step(12);
        check("t5_no_refill", 64'(n_rf), 64'd0);
        start_miss(1'b0);
        step(15);
        check("t5_restart_first_read", 64'(first_rd_rel), 64'd1);
        check("t5_restart_addr_errs", 64'(err_rdaddr), 64'd0);
        check("t5_restart_refill", 64'(rf_rel), 64'd9);
        check("t5_restart_writes", 64'(n_we), 64'd8);

        // 6: miss inputs change under an active refill
        clr();
        t0 = cyc + 1;
        line_miss = 1'b1; replace_dirty = 1'b0; entry_sel = 4'd3; miss_tag = 14'h012;
        step(2);
        entry_sel = 4'd5; miss_tag = 14'h3FF;
        step(3);
        line_miss = 1'b0;
        step(20);
        check("t6_refills", 64'(n_rf), 64'd1);
        check("t6_cmem_writes", 64'(n_we), 64'd8);
        check("t6_entry_errs", 64'(err_addr), 64'd0);
        check("t6_read_addr_errs", 64'(err_rdaddr), 64'd0);
        check("t6_refill_tag", 64'(rtag), 64'h012);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
